pong_render_core: RTL and testbench

Parametrised successor to the Pong pixel generator. It produces 12-bit RGB and the BouncingObject collision flag for every VGA pixel. All scene inputs (ball, paddles, scores, game state) are latched once per frame into shadow registers, so the picture cannot tear mid-frame. Scores render as seven-segment glyphs 0–9. The winner's score blinks in DONE. Output is registered. Sits between the VGA timing generator and the game FSM / collision logic.

---
 rtl/pong_render_core.sv | 185 ++++++++++++++++++
 tb/tb_pong_render_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_render_core.sv
// Pong pixel renderer: frame-shadowed scene, seven-segment scores, registered RGB and collision flag.
// Define CENTER_NET_EN to add a dashed centre net.
module pong_render_core #(
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned BORDER_H     = 8,
   parameter int unsigned PADDLE_OFS   = 8,
   parameter int unsigned PADDLE_W     = 11,
   parameter int unsigned PADDLE_H     = 41,
   parameter int unsigned BALL_SIZE    = 8,
   parameter int unsigned SCORE_W      = 4,
   parameter int unsigned DIGIT1_X     = 226,
   parameter int unsigned DIGIT2_X     = 366,
   parameter int unsigned DIGIT_Y      = 168,
   parameter int unsigned BLINK_FRAMES = 32,
   parameter logic [11:0] FG           = 12'hFFF,
   parameter logic [11:0] BG           = 12'h000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid,
   input  logic [9:0]         h_cnt,
   input  logic [9:0]         v_cnt,
   input  logic [9:0]         ballX,
   input  logic [9:0]         ballY,
   input  logic [9:0]         posX1,
   input  logic [9:0]         posX2,
   input  logic [9:0]         posY1,
   input  logic [9:0]         posY2,
   input  logic [SCORE_W-1:0] score1,
   input  logic [SCORE_W-1:0] score2,
   input  logic [1:0]         game_state,
   input  logic [1:0]         winner,
   output logic [3:0]         vgaRed,
   output logic [3:0]         vgaGreen,
   output logic [3:0]         vgaBlue,
   output logic               BouncingObject,
   output logic               frame_tick
);

   localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [10:0] BORDER_TOP = 11'(BORDER_H);
   localparam logic [10:0] BORDER_BOT = 11'(V_ACTIVE - BORDER_H);
   localparam logic [10:0] OFS        = 11'(PADDLE_OFS);
   localparam logic [10:0] PAD_W_M1   = 11'(PADDLE_W - 1);
   localparam logic [10:0] PAD_H_M1   = 11'(PADDLE_H - 1);
   localparam logic [10:0] BALL_M1    = 11'(BALL_SIZE - 1);
   localparam logic [10:0] D1_X       = 11'(DIGIT1_X);
   localparam logic [10:0] D2_X       = 11'(DIGIT2_X);
   localparam logic [10:0] D_Y        = 11'(DIGIT_Y);

   logic [9:0]         r_ball_x, r_ball_y, r_pos_x1, r_pos_x2, r_pos_y1, r_pos_y2;
   logic [SCORE_W-1:0] r_score1, r_score2;
   logic [1:0]         r_state, r_winner;
   logic               r_shadow_ok;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic [11:0]        r_rgb;
   logic               r_bounce;
   logic               r_frame_tick;

   logic [10:0] w_h, w_v;
   logic [10:0] w_p1_x, w_p1_y, w_p2_x, w_p2_y, w_b_x, w_b_y;
   logic        w_boundary, w_border, w_paddle, w_ball, w_net, w_digit;
   logic [3:0]  w_dig1, w_dig2;
   logic        w_hide1, w_hide2;
   logic [11:0] w_rgb;

   function automatic logic in_rng(input logic [10:0] p, input logic [10:0] lo,
                                   input logic [10:0] hi);
      return (p >= lo) && (p <= hi);
   endfunction

   function automatic logic glyph_hit(input logic [10:0] h, input logic [10:0] v,
                                      input logic [10:0] x0, input logic [3:0] digit);
      logic [10:0] dx, dy;
      logic [6:0]  seg;   // {a,b,c,d,e,f,g}
      logic [6:0]  mask;
      dx     = h - x0;
      dy     = v - D_Y;
      seg[6] = in_rng(dx, 11'd4, 11'd20)  && in_rng(dy, 11'd0, 11'd4);
      seg[5] = in_rng(dx, 11'd20, 11'd24) && in_rng(dy, 11'd4, 11'd18);
      seg[4] = in_rng(dx, 11'd20, 11'd24) && in_rng(dy, 11'd18, 11'd32);
      seg[3] = in_rng(dx, 11'd4, 11'd20)  && in_rng(dy, 11'd32, 11'd36);
      seg[2] = in_rng(dx, 11'd0, 11'd4)   && in_rng(dy, 11'd18, 11'd32);
      seg[1] = in_rng(dx, 11'd0, 11'd4)   && in_rng(dy, 11'd4, 11'd18);
      seg[0] = in_rng(dx, 11'd4, 11'd20)  && in_rng(dy, 11'd16, 11'd20);
      case (digit)
         4'd0:    mask = 7'b1111110;
         4'd1:    mask = 7'b0110000;
         4'd2:    mask = 7'b1101101;
         4'd3:    mask = 7'b1111001;
         4'd4:    mask = 7'b0110011;
         4'd5:    mask = 7'b1011011;
         4'd6:    mask = 7'b1011111;
         4'd7:    mask = 7'b1110000;
         4'd8:    mask = 7'b1111111;
         4'd9:    mask = 7'b1111011;
         default: mask = 7'b0000000;
      endcase
      return in_rng(h, x0, x0 + 11'd24) && in_rng(v, D_Y, D_Y + 11'd36) && (|(seg & mask));
   endfunction

   assign w_h        = {1'b0, h_cnt};
   assign w_v        = {1'b0, v_cnt};
   assign w_boundary = (h_cnt == 10'd0) && (v_cnt == 10'(V_ACTIVE));

   assign w_p1_x = {1'b0, r_pos_x1} + OFS;
   assign w_p1_y = {1'b0, r_pos_y1} + OFS;
   assign w_p2_x = {1'b0, r_pos_x2} + OFS;
   assign w_p2_y = {1'b0, r_pos_y2} + OFS;
   assign w_b_x  = {1'b0, r_ball_x};
   assign w_b_y  = {1'b0, r_ball_y};

   assign w_border = (w_v < BORDER_TOP) || (w_v >= BORDER_BOT);
   assign w_paddle = r_shadow_ok &&
                     ((in_rng(w_h, w_p1_x, w_p1_x + PAD_W_M1) &&
                       in_rng(w_v, w_p1_y, w_p1_y + PAD_H_M1)) ||
                      (in_rng(w_h, w_p2_x, w_p2_x + PAD_W_M1) &&
                       in_rng(w_v, w_p2_y, w_p2_y + PAD_H_M1)));
   assign w_ball   = r_shadow_ok && (r_state != 2'b00) &&
                     in_rng(w_h, w_b_x, w_b_x + BALL_M1) && in_rng(w_v, w_b_y, w_b_y + BALL_M1);

   assign w_dig1  = (r_score1 > SCORE_W'(9)) ? 4'd9 : 4'(r_score1);
   assign w_dig2  = (r_score2 > SCORE_W'(9)) ? 4'd9 : 4'(r_score2);
   assign w_hide1 = (r_state == 2'b11) && (r_winner == 2'b01) &&
                    (r_blink_cnt >= BLINK_W'(BLINK_FRAMES / 2));
   assign w_hide2 = (r_state == 2'b11) && (r_winner == 2'b10) &&
                    (r_blink_cnt >= BLINK_W'(BLINK_FRAMES / 2));
   // Scores are scene content too: nothing but the border draws before the first frame load.
   assign w_digit = r_shadow_ok &&
                    ((!w_hide1 && glyph_hit(w_h, w_v, D1_X, w_dig1)) ||
                     (!w_hide2 && glyph_hit(w_h, w_v, D2_X, w_dig2)));

`ifdef CENTER_NET_EN
   assign w_net = in_rng(w_h, 11'd318, 11'd321) && !v_cnt[4] && !w_border;
`else
   assign w_net = 1'b0;
`endif

   // Every drawn element shares FG, so the priority order collapses to an OR.
   assign w_rgb = !valid ? 12'h000 :
                  (w_border || w_paddle || w_ball || w_net || w_digit) ? FG : BG;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ball_x     <= '0;
         r_ball_y     <= '0;
         r_pos_x1     <= '0;
         r_pos_x2     <= '0;
         r_pos_y1     <= '0;
         r_pos_y2     <= '0;
         r_score1     <= '0;
         r_score2     <= '0;
         r_state      <= '0;
         r_winner     <= '0;
         r_shadow_ok  <= 1'b0;
         r_blink_cnt  <= '0;
         r_rgb        <= '0;
         r_bounce     <= 1'b0;
         r_frame_tick <= 1'b0;
      end else begin
         r_rgb        <= w_rgb;
         r_bounce     <= valid && (w_border || w_paddle);
         r_frame_tick <= w_boundary;
         if (w_boundary) begin
            r_ball_x    <= ballX;
            r_ball_y    <= ballY;
            r_pos_x1    <= posX1;
            r_pos_x2    <= posX2;
            r_pos_y1    <= posY1;
            r_pos_y2    <= posY2;
            r_score1    <= score1;
            r_score2    <= score2;
            r_state     <= game_state;
            r_winner    <= winner;
            r_shadow_ok <= 1'b1;
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
         end
      end
   end

   assign {vgaRed, vgaGreen, vgaBlue} = r_rgb;
   assign BouncingObject              = r_bounce;
   assign frame_tick                  = r_frame_tick;

endmodule

// File: tb/tb_pong_render_core.sv
// Directed bench for pong_render_core: per-cycle check against a rectangle/glyph-table model
// plus hand-computed pixel expectations.
module tb_pong_render_core;

   localparam int V_ACTIVE = 480;
   localparam int BORDER_H = 8;
   localparam int OFS      = 8;
   localparam int PW       = 11;
   localparam int PH       = 41;
   localparam int BALL     = 8;
   localparam int D1X      = 226;
   localparam int D2X      = 366;
   localparam int DY       = 168;
   localparam int BF       = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic [9:0] h_cnt = '0, v_cnt = '0;
   logic [9:0] ballX = '0, ballY = '0, posX1 = '0, posX2 = '0, posY1 = '0, posY2 = '0;
   logic [3:0] score1 = '0, score2 = '0;
   logic [1:0] game_state = '0, winner = '0;
   logic [3:0] vgaRed, vgaGreen, vgaBlue;
   logic       BouncingObject, frame_tick;

   pong_render_core dut (
      .clk(clk), .rst(rst), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .ballX(ballX), .ballY(ballY), .posX1(posX1), .posX2(posX2), .posY1(posY1), .posY2(posY2),
      .score1(score1), .score2(score2), .game_state(game_state), .winner(winner),
      .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
      .BouncingObject(BouncingObject), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int bl      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: segment rectangles (a..g) relative to the glyph box and the lit letters per digit.
   string glyph[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg"};
   int sx0[7] = '{4, 20, 20, 4, 0, 0, 4};
   int sx1[7] = '{20, 24, 24, 20, 4, 4, 20};
   int sy0[7] = '{0, 4, 18, 32, 18, 4, 16};
   int sy1[7] = '{4, 18, 32, 36, 32, 18, 20};

   int m_bx, m_by, m_px1, m_py1, m_px2, m_py2, m_s1, m_s2, m_state, m_win, m_blink;
   bit m_ok;
   logic [11:0] e_rgb;
   bit e_bo, e_tick;
   bit cmp_en = 1'b0;

   function automatic bit in_box(int h, int v, int x, int y, int w, int ht);
      return h >= x && h < x + w && v >= y && v < y + ht;
   endfunction

   function automatic bit digit_on(int h, int v, int x0, int score);
      string g;
      int k;
      bit hit;
      g   = glyph[score > 9 ? 9 : score];
      hit = 1'b0;
      for (int i = 0; i < g.len(); i++) begin
         k = int'(g[i]) - 97;   // letter index from 'a'
         if (h >= x0 + sx0[k] && h <= x0 + sx1[k] && v >= DY + sy0[k] && v <= DY + sy1[k])
            hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic bit m_paddle(int h, int v);
      return m_ok && (in_box(h, v, m_px1 + OFS, m_py1 + OFS, PW, PH) ||
                      in_box(h, v, m_px2 + OFS, m_py2 + OFS, PW, PH));
   endfunction

   function automatic bit m_border(int v);
      return v < BORDER_H || v >= V_ACTIVE - BORDER_H;
   endfunction

   function automatic bit m_fg(int h, int v);
      bit ball, d1, d2, net;
      ball = m_ok && m_state != 0 && in_box(h, v, m_bx, m_by, BALL, BALL);
      d1   = m_ok && !(m_state == 3 && m_win == 1 && m_blink >= BF / 2) && digit_on(h, v, D1X, m_s1);
      d2   = m_ok && !(m_state == 3 && m_win == 2 && m_blink >= BF / 2) && digit_on(h, v, D2X, m_s2);
      net  = 1'b0;
`ifdef CENTER_NET_EN
      net  = h >= 318 && h <= 321 && ((v / 16) % 2 == 0) && !m_border(v);
`endif
      return m_border(v) || m_paddle(h, v) || ball || d1 || d2 || net;
   endfunction

   always @(posedge clk) begin
      cmp_en <= 1'b1;
      if (rst) begin
         e_rgb <= '0; e_bo <= 1'b0; e_tick <= 1'b0;
         m_bx <= 0; m_by <= 0; m_px1 <= 0; m_py1 <= 0; m_px2 <= 0; m_py2 <= 0;
         m_s1 <= 0; m_s2 <= 0; m_state <= 0; m_win <= 0; m_blink <= 0; m_ok <= 1'b0;
      end else begin
         e_rgb  <= (valid && m_fg(int'(h_cnt), int'(v_cnt))) ? 12'hFFF : 12'h000;
         e_bo   <= valid && (m_border(int'(v_cnt)) || m_paddle(int'(h_cnt), int'(v_cnt)));
         e_tick <= h_cnt == 0 && v_cnt == V_ACTIVE;
         if (h_cnt == 0 && v_cnt == V_ACTIVE) begin
            m_bx <= int'(ballX); m_by <= int'(ballY);
            m_px1 <= int'(posX1); m_py1 <= int'(posY1);
            m_px2 <= int'(posX2); m_py2 <= int'(posY2);
            m_s1 <= int'(score1); m_s2 <= int'(score2);
            m_state <= int'(game_state); m_win <= int'(winner);
            m_ok <= 1'b1;
            m_blink <= (m_blink + 1) % BF;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model rgb", {vgaRed, vgaGreen, vgaBlue}, e_rgb);
         check("model bouncing", BouncingObject, e_bo);
         check("model frame_tick", frame_tick, e_tick);
      end
   end

   task automatic drive(input int h, input int v, input bit val);
      @(negedge clk);
      h_cnt = 10'(h);
      v_cnt = 10'(v);
      valid = val;
   endtask

   task automatic chk_px(input string name, input int h, input int v, input logic [11:0] rgb,
                         input bit bo);
      drive(h, v, 1'b1);
      @(posedge clk);
      #1;
      check({name, " rgb"}, {vgaRed, vgaGreen, vgaBlue}, rgb);
      check({name, " bouncing"}, BouncingObject, bo);
   endtask

   task automatic boundary();
      drive(0, V_ACTIVE, 1'b0);
      @(posedge clk);
      #1;
      check("frame_tick pulse", frame_tick, 1'b1);
      bl = (bl + 1) % BF;
   endtask

   initial begin
      ballX = 10'd100; ballY = 10'd100;
      posX1 = 10'd20;  posY1 = 10'd200;
      posX2 = 10'd600; posY2 = 10'd300;
      game_state = 2'b10;
      repeat (3) @(posedge clk);
      #1;
      check("reset rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
      check("reset bouncing", BouncingObject, 1'b0);
      check("reset frame_tick", frame_tick, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Before the first load only the border draws.
      chk_px("pre ball", 100, 100, 12'h000, 1'b0);
      chk_px("pre border", 0, 3, 12'hFFF, 1'b1);
      chk_px("pre paddle", 28, 208, 12'h000, 1'b0);
      boundary();

      chk_px("ball tl", 100, 100, 12'hFFF, 1'b0);
      chk_px("ball br", 107, 107, 12'hFFF, 1'b0);
      chk_px("ball right", 108, 100, 12'h000, 1'b0);
      chk_px("border top in", 0, 7, 12'hFFF, 1'b1);
      chk_px("border top out", 0, 8, 12'h000, 1'b0);
      chk_px("border bot out", 0, 471, 12'h000, 1'b0);
      chk_px("border bot in", 0, 472, 12'hFFF, 1'b1);

      ballX = 10'd200;
      chk_px("ball held", 100, 100, 12'hFFF, 1'b0);
      chk_px("ball new early", 200, 100, 12'h000, 1'b0);
      boundary();
      chk_px("ball moved", 200, 100, 12'hFFF, 1'b0);
      chk_px("ball old gone", 100, 100, 12'h000, 1'b0);

      chk_px("paddle1 tl", 28, 208, 12'hFFF, 1'b1);
      chk_px("paddle1 br", 38, 248, 12'hFFF, 1'b1);
      chk_px("paddle1 right", 39, 208, 12'h000, 1'b0);
      chk_px("paddle2 tl", 608, 308, 12'hFFF, 1'b1);
      chk_px("paddle2 below", 608, 349, 12'h000, 1'b0);
      drive(0, 3, 1'b0);
      @(posedge clk);
      #1;
      check("blank rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
      check("blank bouncing", BouncingObject, 1'b0);

      score1 = 4'd8; score2 = 4'd12;
      boundary();
      chk_px("d1 g", D1X + 10, 186, 12'hFFF, 1'b0);
      chk_px("d1 e", D1X + 2, 193, 12'hFFF, 1'b0);
      chk_px("d1 hole", D1X + 10, 175, 12'h000, 1'b0);
      chk_px("d2 g sat", D2X + 10, 186, 12'hFFF, 1'b0);
      chk_px("d2 e off", D2X + 2, 193, 12'h000, 1'b0);

      game_state = 2'b11; winner = 2'b01; score1 = 4'd3;
      for (int f = 0; f < BF; f++) begin
         boundary();
         chk_px("d1 blink", D1X + 10, 170, (bl < BF / 2) ? 12'hFFF : 12'h000, 1'b0);
         chk_px("d2 steady", D2X + 10, 170, 12'hFFF, 1'b0);
      end
      while (bl != 20) boundary();
      chk_px("d1 blink off", D1X + 10, 170, 12'h000, 1'b0);
      winner = 2'b11;
      boundary();
      chk_px("d1 no-blink winner", D1X + 10, 170, 12'hFFF, 1'b0);

      game_state = 2'b00;
      boundary();
      chk_px("ball hidden start", 200, 100, 12'h000, 1'b0);

      // Reset mid-frame: outputs clear at once, scene stays hidden until the next load.
      @(negedge clk);
      rst = 1'b1;
      h_cnt = 10'd0; v_cnt = 10'd3; valid = 1'b1;
      @(posedge clk);
      #1;
      check("midrst rgb", {vgaRed, vgaGreen, vgaBlue}, 12'h000);
      check("midrst bouncing", BouncingObject, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      bl = 0;
      chk_px("post rst border", 0, 3, 12'hFFF, 1'b1);
      chk_px("post rst paddle", 28, 208, 12'h000, 1'b0);
      boundary();
      chk_px("reloaded paddle", 28, 208, 12'hFFF, 1'b1);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
